// File: rtl/unidade_acesso_memoria_pkg.sv
// Shared constants and state encoding for the memory access unit.
// The linear word address is split into a RAM row and column.
package unidade_acesso_memoria_pkg;
   localparam int LINHAS         = 11;
   localparam int COLUNAS        = 11;
   localparam int TOTAL_PALAVRAS = LINHAS * COLUNAS;
   localparam int ADDR_W         = 7;
   localparam int DADO_W         = 32;
   localparam int RAM_END_W      = 11;

   typedef enum logic [2:0] {
      OCIOSO,
      DIVIDE,
      ACESSO,
      CONCLUIDO,
      ERRO
   } estado_t;
endpackage

// File: rtl/unidade_acesso_memoria_divisor.sv
// Iterative divide by COLUNAS using one subtraction per cycle.
// valido stays high once resto has dropped below COLUNAS.
module divisor_linha_coluna #(
   parameter int COLUNAS = 11,
   parameter int W       = 7
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         start,
   input  logic [W-1:0] dividend,
   output logic [W-1:0] quociente,
   output logic [W-1:0] resto,
   output logic         valido
);
   localparam logic [W-1:0] COL_W = W'(COLUNAS);

   logic [W-1:0] quoc_q, quoc_d;
   logic [W-1:0] resto_q, resto_d;

   always_comb begin
      quoc_d  = quoc_q;
      resto_d = resto_q;
      if (start) begin
         quoc_d  = '0;
         resto_d = dividend;
      end else if (resto_q >= COL_W) begin
         resto_d = resto_q - COL_W;
         quoc_d  = quoc_q + W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         quoc_q  <= '0;
         resto_q <= '0;
      end else begin
         quoc_q  <= quoc_d;
         resto_q <= resto_d;
      end
   end

   assign quociente = quoc_q;
   assign resto     = resto_q;
   assign valido    = (resto_q < COL_W);
endmodule

// File: rtl/unidade_acesso_memoria.sv
// Single-port memory access unit: linear address -> (row, column), then one
// registered RAM access. All outputs come straight from flops.
module unidade_acesso_memoria #(
   parameter int LINHAS  = unidade_acesso_memoria_pkg::LINHAS,
   parameter int COLUNAS = unidade_acesso_memoria_pkg::COLUNAS
) (
   input  logic                                         clock,
   input  logic                                         reset,
   input  logic                                         req,
   input  logic                                         store,
   input  logic [unidade_acesso_memoria_pkg::ADDR_W-1:0]    endereco,
   input  logic [unidade_acesso_memoria_pkg::DADO_W-1:0]    dado_escrita,
   input  logic [unidade_acesso_memoria_pkg::DADO_W-1:0]    ram_saida,
   output logic [unidade_acesso_memoria_pkg::DADO_W-1:0]    ram_dados,
   output logic [unidade_acesso_memoria_pkg::RAM_END_W-1:0] ram_linha,
   output logic [unidade_acesso_memoria_pkg::RAM_END_W-1:0] ram_coluna,
   output logic                                         ram_write,
   output logic                                         ocupado,
   output logic                                         pronto,
   output logic [unidade_acesso_memoria_pkg::DADO_W-1:0]    dado_lido,
   output logic                                         erro
);
   import unidade_acesso_memoria_pkg::*;

   localparam int MAX_END = LINHAS * COLUNAS - 1;

   estado_t estado_q, estado_d;

   logic                 store_q, store_d;
   logic [DADO_W-1:0]    ram_dados_q, ram_dados_d;
   logic [RAM_END_W-1:0] linha_q, linha_d;
   logic [RAM_END_W-1:0] coluna_q, coluna_d;
   logic                 ram_write_q, ram_write_d;
   logic                 ocupado_q, ocupado_d;
   logic                 pronto_q, pronto_d;
   logic                 erro_q, erro_d;
   logic [DADO_W-1:0]    lido_q, lido_d;

   logic              div_start;
   logic [ADDR_W-1:0] div_quoc, div_resto;
   logic              div_valido;

   divisor_linha_coluna #(
      .COLUNAS (COLUNAS),
      .W       (ADDR_W)
   ) u_divisor (
      .clock     (clock),
      .reset     (reset),
      .start     (div_start),
      .dividend  (endereco),
      .quociente (div_quoc),
      .resto     (div_resto),
      .valido    (div_valido)
   );

   always_ff @(posedge clock) begin
      if (!reset) estado_q <= OCIOSO;
      else        estado_q <= estado_d;
   end

   always_comb begin
      estado_d    = estado_q;
      store_d     = store_q;
      ram_dados_d = ram_dados_q;
      linha_d     = linha_q;
      coluna_d    = coluna_q;
      lido_d      = lido_q;
      div_start   = 1'b0;
      case (estado_q)
         OCIOSO: begin
            if (req) begin
               div_start   = 1'b1;
               store_d     = store;
               ram_dados_d = dado_escrita;
               estado_d    = (int'(endereco) > MAX_END) ? ERRO : DIVIDE;
            end
         end
         DIVIDE: begin
            if (div_valido) begin
               linha_d  = RAM_END_W'(div_quoc);
               coluna_d = RAM_END_W'(div_resto);
               estado_d = ACESSO;
            end
         end
         ACESSO: begin
            if (!store_q) lido_d = ram_saida;
            estado_d = CONCLUIDO;
         end
         CONCLUIDO: estado_d = OCIOSO;
         ERRO:      estado_d = OCIOSO;
         default:   estado_d = OCIOSO;
      endcase
      // Status flops are loaded from the next state so they line up with it.
      ram_write_d = (estado_d == ACESSO) && store_q;
      pronto_d    = (estado_d == CONCLUIDO);
      erro_d      = (estado_d == ERRO);
      ocupado_d   = (estado_d != OCIOSO);
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         store_q     <= 1'b0;
         ram_dados_q <= '0;
         linha_q     <= '0;
         coluna_q    <= '0;
         ram_write_q <= 1'b0;
         ocupado_q   <= 1'b0;
         pronto_q    <= 1'b0;
         erro_q      <= 1'b0;
         lido_q      <= '0;
      end else begin
         store_q     <= store_d;
         ram_dados_q <= ram_dados_d;
         linha_q     <= linha_d;
         coluna_q    <= coluna_d;
         ram_write_q <= ram_write_d;
         ocupado_q   <= ocupado_d;
         pronto_q    <= pronto_d;
         erro_q      <= erro_d;
         lido_q      <= lido_d;
      end
   end

   assign ram_dados  = ram_dados_q;
   assign ram_linha  = linha_q;
   assign ram_coluna = coluna_q;
   assign ram_write  = ram_write_q;
   assign ocupado    = ocupado_q;
   assign pronto     = pronto_q;
   assign erro       = erro_q;
   assign dado_lido  = lido_q;
endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Randomized bench for unidade_acesso_memoria against a word-array reference
// model; expected timing is derived from address / 11 arithmetic.
module tb_unidade_acesso_memoria;
   logic        clock = 1'b0;
   logic        reset;
   logic        req;
   logic        store;
   logic [6:0]  endereco;
   logic [31:0] dado_escrita;
   logic [31:0] ram_saida;
   logic [31:0] ram_dados;
   logic [10:0] ram_linha;
   logic [10:0] ram_coluna;
   logic        ram_write;
   logic        ocupado;
   logic        pronto;
   logic [31:0] dado_lido;
   logic        erro;

   int n_cmp = 0;
   int n_err = 0;

   // RAM behind the DUT, preloadable from the bench
   logic [31:0] mem [0:120];
   logic        pl_en = 1'b0;
   int          pl_idx = 0;
   logic [31:0] pl_dat = '0;
   int          ram_idx;

   // reference model state
   logic [31:0] ref_mem [0:120];
   logic [31:0] ref_lido;

   unidade_acesso_memoria dut (
      .clock        (clock),
      .reset        (reset),
      .req          (req),
      .store        (store),
      .endereco     (endereco),
      .dado_escrita (dado_escrita),
      .ram_saida    (ram_saida),
      .ram_dados    (ram_dados),
      .ram_linha    (ram_linha),
      .ram_coluna   (ram_coluna),
      .ram_write    (ram_write),
      .ocupado      (ocupado),
      .pronto       (pronto),
      .dado_lido    (dado_lido),
      .erro         (erro)
   );

   always #5 clock = ~clock;

   assign ram_idx   = int'(ram_linha) * 11 + int'(ram_coluna);
   assign ram_saida = (ram_idx < 121) ? mem[ram_idx] : 32'h0;

   always @(posedge clock) begin
      if (pl_en) mem[pl_idx] <= pl_dat;
      else if (ram_write && ram_idx < 121) mem[ram_idx] <= ram_dados;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_cmp++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: obtido=%h esperado=%h", tag, obs, esp);
      end
   endtask

   task automatic preload(input int idx, input logic [31:0] d);
      @(negedge clock);
      pl_en = 1'b1; pl_idx = idx; pl_dat = d;
      ref_mem[idx] = d;
      @(negedge clock);
      pl_en = 1'b0;
   endtask

   // One request with random noise on req while busy; checks timing and effects.
   task automatic transacao(input logic [6:0] a, input logic st, input logic [31:0] d);
      int q, r, fim, n_wr, c_wr, n_pr, c_pr, n_er, c_er;
      logic err;
      logic [31:0] lin_obs, col_obs, dad_obs, lido_esp;
      err = (int'(a) > 120);
      q = int'(a) / 11;
      r = int'(a) % 11;
      fim = err ? 2 : q + 4;
      lido_esp = (err || st) ? ref_lido : ref_mem[a];
      n_wr = 0; c_wr = -1; n_pr = 0; c_pr = -1; n_er = 0; c_er = -1;
      lin_obs = '0; col_obs = '0; dad_obs = '0;
      @(negedge clock);
      req = 1'b1; store = st; endereco = a; dado_escrita = d;
      for (int c = 1; c <= fim; c++) begin
         @(negedge clock);
         if (c == 1) chk("ocupado_inicio", {31'b0, ocupado}, 32'd1);
         if (ram_write) begin
            n_wr++; c_wr = c;
            lin_obs = {21'b0, ram_linha}; col_obs = {21'b0, ram_coluna}; dad_obs = ram_dados;
         end
         if (pronto) begin n_pr++; c_pr = c; end
         if (erro)   begin n_er++; c_er = c; end
         if (c < fim) begin
            req = 1'($urandom_range(0, 1));
            store = 1'($urandom); endereco = 7'($urandom); dado_escrita = $urandom;
         end else begin
            req = 1'b0;
            chk("ocupado_fim", {31'b0, ocupado}, 32'd0);
         end
      end
      if (err) begin
         chk("erro_qtd", n_er, 1);
         chk("erro_ciclo", c_er, 1);
         chk("erro_sem_pronto", n_pr, 0);
         chk("erro_sem_escrita", n_wr, 0);
      end else begin
         chk("escritas", n_wr, st ? 1 : 0);
         if (st) begin
            chk("escrita_ciclo", c_wr, q + 2);
            chk("linha", lin_obs, q);
            chk("coluna", col_obs, r);
            chk("ram_dados", dad_obs, d);
         end
         chk("pronto_qtd", n_pr, 1);
         chk("pronto_ciclo", c_pr, q + 3);
         chk("sem_erro", n_er, 0);
         if (st) ref_mem[a] = d;
         else    ref_lido = ref_mem[a];
      end
      chk("dado_lido", dado_lido, lido_esp);
   endtask

   initial begin
      int n_wr, n_pr, m_wr, m_pr;
      reset = 1'b0; req = 1'b1; store = 1'b1; endereco = 7'd5; dado_escrita = 32'hFFFF_FFFF;
      ref_lido = '0;
      for (int i = 0; i < 121; i++) preload(i, $urandom);
      chk("rst_ocupado", {31'b0, ocupado}, 32'd0);
      chk("rst_write", {31'b0, ram_write}, 32'd0);
      chk("rst_pronto", {31'b0, pronto}, 32'd0);
      chk("rst_erro", {31'b0, erro}, 32'd0);
      chk("rst_lido", dado_lido, 32'd0);
      chk("rst_linha", {21'b0, ram_linha}, 32'd0);
      chk("rst_coluna", {21'b0, ram_coluna}, 32'd0);
      chk("rst_dados", ram_dados, 32'd0);
      req = 1'b0;
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // directed cases
      transacao(7'd25, 1'b1, 32'hDEADBEEF);
      preload(120, 32'h12345678);
      transacao(7'd120, 1'b0, 32'h0);
      chk("load_120", dado_lido, 32'h12345678);
      transacao(7'd0, 1'b1, 32'hA5A5_0000);
      transacao(7'd0, 1'b0, 32'h0);
      transacao(7'd121, 1'b1, 32'h1111_1111);
      transacao(7'd127, 1'b0, 32'h2222_2222);
      transacao(7'd25, 1'b0, 32'h0);
      transacao(7'd120, 1'b1, 32'hCAFE_F00D);
      transacao(7'd120, 1'b0, 32'h0);

      // reset during cycle 3 of a store to 110
      @(negedge clock);
      req = 1'b1; store = 1'b1; endereco = 7'd110; dado_escrita = 32'hBAD0_BAD0;
      @(negedge clock); req = 1'b0;
      @(negedge clock);
      @(negedge clock); reset = 1'b0; req = 1'b1;
      @(negedge clock);
      chk("abort_ocupado", {31'b0, ocupado}, 32'd0);
      chk("abort_write", {31'b0, ram_write}, 32'd0);
      chk("abort_pronto", {31'b0, pronto}, 32'd0);
      chk("abort_lido", dado_lido, 32'd0);
      chk("abort_linha", {21'b0, ram_linha}, 32'd0);
      chk("abort_coluna", {21'b0, ram_coluna}, 32'd0);
      chk("abort_dados", ram_dados, 32'd0);
      reset = 1'b1; req = 1'b0;
      ref_lido = '0;
      n_wr = 0; n_pr = 0;
      for (int c = 0; c < 15; c++) begin
         @(negedge clock);
         if (ram_write) n_wr++;
         if (pronto) n_pr++;
      end
      chk("abort_sem_escrita", n_wr, 0);
      chk("abort_sem_pronto", n_pr, 0);
      transacao(7'd110, 1'b0, 32'h0);

      // req held high: store 0 then 11 back to back
      @(negedge clock);
      req = 1'b1; store = 1'b1; endereco = 7'd0; dado_escrita = 32'h0000_AAAA;
      m_wr = 0; m_pr = 0;
      for (int c = 1; c <= 9; c++) begin
         @(negedge clock);
         if (ram_write) begin
            m_wr = m_wr | (1 << c);
            if (c == 2) begin
               chk("b2b_linha0", {21'b0, ram_linha}, 32'd0);
               chk("b2b_coluna0", {21'b0, ram_coluna}, 32'd0);
            end
            if (c == 7) begin
               chk("b2b_linha1", {21'b0, ram_linha}, 32'd1);
               chk("b2b_coluna1", {21'b0, ram_coluna}, 32'd0);
            end
         end
         if (pronto) m_pr = m_pr | (1 << c);
         if (c == 1) begin endereco = 7'd11; dado_escrita = 32'h0000_BBBB; end
         if (c == 4) chk("b2b_ocioso", {31'b0, ocupado}, 32'd0);
         if (c == 5) req = 1'b0;
      end
      chk("b2b_escritas", m_wr, (1 << 2) | (1 << 7));
      chk("b2b_prontos", m_pr, (1 << 3) | (1 << 8));
      ref_mem[0]  = 32'h0000_AAAA;
      ref_mem[11] = 32'h0000_BBBB;
      transacao(7'd0, 1'b0, 32'h0);
      transacao(7'd11, 1'b0, 32'h0);

      // random traffic, biased towards a small window so loads hit stores
      for (int i = 0; i < 60; i++) begin
         logic [6:0] a;
         a = ($urandom_range(0, 3) == 0) ? 7'($urandom) : 7'($urandom_range(0, 30));
         transacao(a, 1'($urandom), $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
